// File: rtl/esdi_pkg.sv
// Shared definitions for the ESDI command/status serial transfer block:
// FSM encoding, transfer length and odd-parity helpers.
package esdi_pkg;

  localparam logic [4:0] CMD_BITS = 5'd17;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    C_ACK    = 3'd1,
    C_REL    = 3'd2,
    DISPATCH = 3'd3,
    R_WAIT   = 3'd4,
    R_ACK    = 3'd5,
    R_REL    = 3'd6
  } esdi_state_e;

  // Parity bit that makes a 16-bit word plus the bit carry an odd number of ones.
  function automatic logic odd_parity_bit(input logic [15:0] word);
    return ~(^word);
  endfunction

  function automatic logic odd_parity_ok(input logic [16:0] frame);
    return ^frame;
  endfunction

endpackage

// File: rtl/esdi_sync.sv
// Single-bit multi-flop synchronizer for host-domain ESDI signals.
module esdi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;
  logic [STAGES:0]   chain_ext_s;

  assign chain_ext_s = {chain_r, d};
  assign q           = chain_r[STAGES-1];

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_r <= {STAGES{1'b0}};
    end else begin
      chain_r <= chain_ext_s[STAGES-1:0];
    end
  end

endmodule

// File: rtl/esdi_cmd_xfer.sv
// ESDI serial command receiver / config-status transmitter with a
// req/ack bit handshake, odd parity and an inter-edge idle timeout.
module esdi_cmd_xfer
  import esdi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        esdi_transfer_req,
  input  logic        esdi_command_data,
  output logic        esdi_transfer_ack,
  output logic        esdi_confstat_data,
  output logic        esdi_command_complete,
  output logic        cmd_valid,
  output logic [15:0] cmd_word,
  input  logic        rsp_valid,
  input  logic        rsp_has_data,
  input  logic [15:0] rsp_word,
  output logic        parity_err,
  output logic        xfer_abort
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic req_s, data_s, req_d_r, req_rise_s, req_fall_s;

  esdi_state_e state_r, next_state_s;
  logic             ack_r, ack_nxt_s;
  logic             conf_r, conf_nxt_s;
  logic             cc_r;
  logic             cmd_valid_r, cmd_valid_nxt_s;
  logic [15:0]      cmd_word_r, cmd_word_nxt_s;
  logic [16:0]      shift_r, shift_nxt_s;
  logic [16:0]      rsp_shift_r, rsp_shift_nxt_s;
  logic [4:0]       bit_cnt_r, bit_cnt_nxt_s;
  logic [CNT_W-1:0] idle_cnt_r, idle_cnt_nxt_s;
  logic             perr_r, perr_nxt_s;
  logic             abort_r, abort_nxt_s;
  logic             cnt_active_s, timeout_s;

  esdi_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk (clk),
    .rst (rst),
    .d   (esdi_transfer_req),
    .q   (req_s)
  );

  esdi_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk (clk),
    .rst (rst),
    .d   (esdi_command_data),
    .q   (data_s)
  );

  assign req_rise_s   = req_s & ~req_d_r;
  assign req_fall_s   = ~req_s & req_d_r;
  assign cnt_active_s = (state_r != IDLE) && (state_r != DISPATCH);
  assign timeout_s    = cnt_active_s && (idle_cnt_r == CNT_W'(TIMEOUT_CYC));

  // Next-state and next-output logic for the handshake FSM.
  always_comb begin
    next_state_s    = state_r;
    ack_nxt_s       = ack_r;
    conf_nxt_s      = 1'b0;
    cmd_valid_nxt_s = cmd_valid_r;
    cmd_word_nxt_s  = cmd_word_r;
    shift_nxt_s     = shift_r;
    rsp_shift_nxt_s = rsp_shift_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    perr_nxt_s      = 1'b0;
    abort_nxt_s     = 1'b0;

    if (!cnt_active_s || req_rise_s || req_fall_s) begin
      idle_cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      idle_cnt_nxt_s = idle_cnt_r + CNT_W'(1'b1);
    end

    case (state_r)
      IDLE: begin
        if (req_rise_s) begin
          shift_nxt_s   = {16'd0, data_s};
          bit_cnt_nxt_s = 5'd1;
          ack_nxt_s     = 1'b1;
          next_state_s  = C_ACK;
        end else begin
          bit_cnt_nxt_s = 5'd0;
        end
      end
      C_ACK: begin
        if (req_fall_s) begin
          ack_nxt_s = 1'b0;
          if (bit_cnt_r == CMD_BITS) begin
            bit_cnt_nxt_s = 5'd0;
            if (odd_parity_ok(shift_r)) begin
              cmd_valid_nxt_s = 1'b1;
              cmd_word_nxt_s  = shift_r[16:1];
              next_state_s    = DISPATCH;
            end else begin
              perr_nxt_s   = 1'b1;
              next_state_s = IDLE;
            end
          end else begin
            next_state_s = C_REL;
          end
        end else begin
          ack_nxt_s = 1'b1;
        end
      end
      C_REL: begin
        if (req_rise_s) begin
          shift_nxt_s   = {shift_r[15:0], data_s};
          bit_cnt_nxt_s = bit_cnt_r + 5'd1;
          ack_nxt_s     = 1'b1;
          next_state_s  = C_ACK;
        end else begin
          ack_nxt_s = 1'b0;
        end
      end
      DISPATCH: begin
        // Host edges are deliberately ignored until the decoder answers.
        if (rsp_valid) begin
          cmd_valid_nxt_s = 1'b0;
          bit_cnt_nxt_s   = 5'd0;
          if (rsp_has_data) begin
            rsp_shift_nxt_s = {rsp_word, odd_parity_bit(rsp_word)};
            next_state_s    = R_WAIT;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          ack_nxt_s = 1'b0;
        end
      end
      R_WAIT, R_REL: begin
        if (req_rise_s) begin
          conf_nxt_s   = rsp_shift_r[16];
          next_state_s = R_ACK;
        end else begin
          ack_nxt_s = 1'b0;
        end
      end
      R_ACK: begin
        if (req_fall_s) begin
          ack_nxt_s       = 1'b0;
          rsp_shift_nxt_s = {rsp_shift_r[15:0], 1'b0};
          if (bit_cnt_r == (CMD_BITS - 5'd1)) begin
            bit_cnt_nxt_s = 5'd0;
            next_state_s  = IDLE;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 5'd1;
            next_state_s  = R_REL;
          end
        end else begin
          ack_nxt_s  = 1'b1;
          conf_nxt_s = conf_r;
        end
      end
      default: begin
        next_state_s = IDLE;
        ack_nxt_s    = 1'b0;
      end
    endcase

    if (timeout_s) begin
      next_state_s    = IDLE;
      ack_nxt_s       = 1'b0;
      conf_nxt_s      = 1'b0;
      cmd_valid_nxt_s = 1'b0;
      bit_cnt_nxt_s   = 5'd0;
      idle_cnt_nxt_s  = {CNT_W{1'b0}};
      abort_nxt_s     = 1'b1;
    end else begin
      abort_nxt_s = 1'b0;
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      req_d_r     <= 1'b0;
      ack_r       <= 1'b0;
      conf_r      <= 1'b0;
      cc_r        <= 1'b1;
      cmd_valid_r <= 1'b0;
      cmd_word_r  <= 16'd0;
      shift_r     <= 17'd0;
      rsp_shift_r <= 17'd0;
      bit_cnt_r   <= 5'd0;
      idle_cnt_r  <= {CNT_W{1'b0}};
      perr_r      <= 1'b0;
      abort_r     <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      req_d_r     <= req_s;
      ack_r       <= ack_nxt_s;
      conf_r      <= conf_nxt_s;
      cc_r        <= (next_state_s == IDLE);
      cmd_valid_r <= cmd_valid_nxt_s;
      cmd_word_r  <= cmd_word_nxt_s;
      shift_r     <= shift_nxt_s;
      rsp_shift_r <= rsp_shift_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      idle_cnt_r  <= idle_cnt_nxt_s;
      perr_r      <= perr_nxt_s;
      abort_r     <= abort_nxt_s;
    end
  end

  assign esdi_transfer_ack     = ack_r;
  assign esdi_confstat_data    = conf_r;
  assign esdi_command_complete = cc_r;
  assign cmd_valid             = cmd_valid_r;
  assign cmd_word              = cmd_word_r;
  assign parity_err            = perr_r;
  assign xfer_abort            = abort_r;

endmodule

// File: doc/esdi_cmd_xfer.md
ESDI_CMD_XFER -- requirements
Module: esdi_cmd_xfer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below, clock and reset first.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth for esdi_transfer_req and esdi_command_data.
REQ-003 Parameter TIMEOUT_CYC, default 65535, SHALL set the idle-cycle limit between handshake edges before an abort.
REQ-004 Port clk  in  1  system clock.
REQ-005 Port rst  in  1  async active-high reset.
REQ-006 Port esdi_transfer_req  in  1  host transfer request, active-high (inversion done upstream).
REQ-007 Port esdi_command_data  in  1  host serial command bit.
REQ-008 Port esdi_transfer_ack  out  1  drive transfer acknowledge.
REQ-009 Port esdi_confstat_data  out  1  serial config/status bit to host.
REQ-010 Port esdi_command_complete  out  1  high when no command is in progress.
REQ-011 Port cmd_valid  out  1  received command is held for the decoder.
REQ-012 Port cmd_word  out  16  received command, bit 15 first on the wire.
REQ-013 Port rsp_valid  in  1  decoder has finished the command (one-cycle pulse).
REQ-014 Port rsp_has_data  in  1  qualifies rsp_valid: 1 means a 16-bit response is to be returned.
REQ-015 Port rsp_word  in  16  response word, sampled when rsp_valid is high.
REQ-016 Port parity_err  out  1  one-cycle pulse on a command parity failure.
REQ-017 Port xfer_abort  out  1  one-cycle pulse on a timeout abort.

Function
REQ-018 esdi_transfer_req and esdi_command_data SHALL pass through identical SYNC_STAGES flop chains; all edge detection SHALL use the synchronized req.
REQ-019 The FSM SHALL have the states IDLE, C_ACK, C_REL, DISPATCH, R_WAIT, R_ACK, R_REL.
REQ-020 Command phase: on a synchronized req rising edge in IDLE/C_REL the block SHALL shift in the synchronized data bit, enter C_ACK, and assert ack.
REQ-021 In C_ACK the block SHALL hold ack until req falls, then drop ack (C_REL); 17 bits are received: 16 command bits, MSB first, then 1 parity bit.
REQ-022 esdi_command_complete SHALL fall in the cycle the first command bit is sampled and rise on return to IDLE.
REQ-023 Parity SHALL be odd over all 17 bits; after the 17th ack falls, a good word SHALL assert cmd_valid and enter DISPATCH.
REQ-024 On a parity failure the block SHALL pulse parity_err, leave cmd_valid low, and return to IDLE.
REQ-025 cmd_valid and cmd_word SHALL stay stable until rsp_valid; cmd_valid SHALL clear in the cycle after rsp_valid.
REQ-026 On rsp_valid with rsp_has_data=0 the block SHALL enter IDLE; with rsp_has_data=1 it SHALL latch rsp_word plus its odd-parity bit and enter R_WAIT.
REQ-027 Response phase: on a req rising edge in R_WAIT the block SHALL drive the current bit on confstat_data that cycle, assert ack one cycle later (R_ACK), and hold confstat stable until req falls.
REQ-028 On req falling in R_ACK the block SHALL drop ack and advance the bit; after the 17th bit it SHALL enter IDLE.
REQ-029 confstat_data SHALL be 0 whenever no response bit is being presented.
REQ-030 A req edge arriving in DISPATCH SHALL be ignored; ack SHALL stay low.
REQ-031 An idle counter SHALL run in every state except IDLE and DISPATCH, clearing on each req edge; on reaching TIMEOUT_CYC it SHALL pulse xfer_abort, drop ack and cmd_valid, and return to IDLE.
REQ-032 rsp_valid outside DISPATCH SHALL be ignored.

Reset
REQ-033 Reset SHALL force IDLE, ack=0, confstat_data=0, command_complete=1, cmd_valid=0, cmd_word=0, parity_err=0, xfer_abort=0, bit counter=0, idle counter=0, and all sync flops=0.
REQ-034 Reset asserted mid-transfer SHALL discard the partial word with no pulses generated; the first req rise after reset is bit 15 of a new command.

Structure
REQ-035 The state encoding, CMD_BITS=17, and the odd-parity function SHALL live in the shared package esdi_pkg.
REQ-036 The 1-bit synchronizer SHALL be the sub-module esdi_sync, instantiated twice.

Verification
REQ-037 Send command 0x1234 with parity 0 -> cmd_valid=1, cmd_word=0x1234, command_complete low until rsp_valid (rsp_has_data=0), then high.
REQ-038 Send 0x0000 with parity 0 -> one parity_err pulse, cmd_valid stays 0, state returns to IDLE.
REQ-039 Send 0x0000 with parity 1, then rsp_valid with rsp_has_data=1 and rsp_word=0xA5A5 -> host reads 1010010110100101 followed by parity bit 1, and 17 acks occur.
REQ-040 Stop req after 5 command bits -> xfer_abort pulses at TIMEOUT_CYC, and the next 17-bit command 0x8001 with parity 1 is received correctly.
REQ-041 Assert rst while ack is high mid-command -> ack=0 and command_complete=1 immediately, then command 0xFFFF with parity 1 decodes correctly.
REQ-042 Toggle req during DISPATCH -> no ack and cmd_word unchanged.
